ledr_pattern_sequencer: RTL



---
 rtl/ledr_pattern_sequencer.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/ledr_pattern_sequencer.sv
// rtl/ledr_pattern_sequencer.sv - Avalon-MM LED port with direct writes and a timed pattern-table sequencer
module ledr_pattern_sequencer #(
  parameter int DATA_W  = 16,
  parameter int DEPTH   = 16,
  parameter int IDX_W   = $clog2(DEPTH),
  parameter int PRESC_W = 24
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [DATA_W-1:0] out_port,
  output logic              irq
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HOLD} state_t;

  localparam logic [2:0] A_CTRL     = 3'd0;
  localparam logic [2:0] A_STATUS   = 3'd1;
  localparam logic [2:0] A_DIRECT   = 3'd2;
  localparam logic [2:0] A_PERIOD   = 3'd3;
  localparam logic [2:0] A_LENGTH   = 3'd4;
  localparam logic [2:0] A_PAT_ADDR = 3'd5;
  localparam logic [2:0] A_PAT_DATA = 3'd6;

  localparam logic [IDX_W:0]   LEN_ONE   = (IDX_W+1)'(1);
  localparam logic [IDX_W:0]   LEN_DEPTH = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
  localparam logic [PRESC_W-1:0] CNT_ONE = PRESC_W'(1);

  state_t              state_q, state_d;
  logic                run_q, run_d;
  logic                loop_q, loop_d;
  logic                mode_q, mode_d;
  logic                irq_en_q, irq_en_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   direct_q, direct_d;
  logic [DATA_W-1:0]   out_q, out_d;
  logic [PRESC_W-1:0]  period_q, period_d;
  logic [PRESC_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W:0]      length_q, length_d;
  logic [IDX_W-1:0]    pat_addr_q, pat_addr_d;
  logic [IDX_W-1:0]    index_q, index_d;
  logic [DATA_W-1:0]   pat_mem_q [DEPTH];

  logic                wr_en, ctrl_wr, start_req, pat_we;
  logic [IDX_W:0]      eff_len;
  logic                last_entry;
  logic [IDX_W-1:0]    index_nxt;
  logic                unused_wdata;

  assign wr_en     = chipselect & ~write_n;
  assign ctrl_wr   = wr_en && (address == A_CTRL);
  assign start_req = ctrl_wr && writedata[0] && writedata[2];
  assign pat_we    = wr_en && (address == A_PAT_DATA);
  assign index_nxt = index_q + IDX_ONE;
  assign unused_wdata = ^writedata;

  // LENGTH of 0 acts as 1 and anything past DEPTH is capped.
  always_comb begin
    eff_len = length_q;
    if (length_q == '0) begin
      eff_len = LEN_ONE;
    end else if (length_q > LEN_DEPTH) begin
      eff_len = LEN_DEPTH;
    end
  end

  assign last_entry = ({1'b0, index_q} + LEN_ONE) >= eff_len;

  always_comb begin
    state_d    = state_q;
    run_d      = run_q;
    loop_d     = loop_q;
    mode_d     = mode_q;
    irq_en_d   = irq_en_q;
    done_d     = done_q;
    direct_d   = direct_q;
    out_d      = out_q;
    period_d   = period_q;
    cnt_d      = cnt_q;
    length_d   = length_q;
    pat_addr_d = pat_addr_q;
    index_d    = index_q;

    if (wr_en) begin
      case (address)
        A_CTRL: begin
          run_d    = writedata[0];
          loop_d   = writedata[1];
          mode_d   = writedata[2];
          irq_en_d = writedata[3];
        end
        A_STATUS:   if (writedata[1]) done_d = 1'b0;
        A_DIRECT:   direct_d   = writedata[DATA_W-1:0];
        A_PERIOD:   period_d   = writedata[PRESC_W-1:0];
        A_LENGTH:   length_d   = writedata[IDX_W:0];
        A_PAT_ADDR: pat_addr_d = writedata[IDX_W-1:0];
        A_PAT_DATA: pat_addr_d = pat_addr_q + IDX_ONE;
        default: ;
      endcase
    end

    // Sequencer; placed after the W1C so a same-edge done set wins.
    case (state_q)
      ST_IDLE: begin
        out_d = direct_q;
        if (start_req) begin
          state_d = ST_RUN;
          index_d = '0;
          cnt_d   = '0;
          out_d   = pat_mem_q[0];
        end
      end
      ST_RUN: begin
        if (start_req) begin
          index_d = '0;
          cnt_d   = '0;
          out_d   = pat_mem_q[0];
        end else if (ctrl_wr) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == period_q) begin
            if (!last_entry) begin
              index_d = index_nxt;
              cnt_d   = '0;
              out_d   = pat_mem_q[index_nxt];
            end else if (loop_q) begin
              index_d = '0;
              cnt_d   = '0;
              out_d   = pat_mem_q[0];
            end else begin
              state_d = ST_HOLD;
              done_d  = 1'b1;
              run_d   = 1'b0;
            end
          end
        end
      end
      ST_HOLD: begin
        if (start_req) begin
          state_d = ST_RUN;
          index_d = '0;
          cnt_d   = '0;
          out_d   = pat_mem_q[0];
        end else if (ctrl_wr) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      run_q      <= 1'b0;
      loop_q     <= 1'b0;
      mode_q     <= 1'b0;
      irq_en_q   <= 1'b0;
      done_q     <= 1'b0;
      direct_q   <= '0;
      out_q      <= '0;
      period_q   <= '0;
      cnt_q      <= '0;
      length_q   <= '0;
      pat_addr_q <= '0;
      index_q    <= '0;
    end else begin
      state_q    <= state_d;
      run_q      <= run_d;
      loop_q     <= loop_d;
      mode_q     <= mode_d;
      irq_en_q   <= irq_en_d;
      done_q     <= done_d;
      direct_q   <= direct_d;
      out_q      <= out_d;
      period_q   <= period_d;
      cnt_q      <= cnt_d;
      length_q   <= length_d;
      pat_addr_q <= pat_addr_d;
      index_q    <= index_d;
    end
  end

  // Pattern table contents are not reset.
  always_ff @(posedge clk) begin
    if (pat_we) pat_mem_q[pat_addr_q] <= writedata[DATA_W-1:0];
  end

  always_comb begin
    readdata = '0;
    case (address)
      A_CTRL:     readdata[3:0] = {irq_en_q, mode_q, loop_q, run_q};
      A_STATUS: begin
        readdata[0]          = (state_q == ST_RUN);
        readdata[1]          = done_q;
        readdata[2]          = (state_q == ST_HOLD);
        readdata[8 +: IDX_W] = index_q;
      end
      A_DIRECT:   readdata[DATA_W-1:0]  = direct_q;
      A_PERIOD:   readdata[PRESC_W-1:0] = period_q;
      A_LENGTH:   readdata[IDX_W:0]     = length_q;
      A_PAT_ADDR: readdata[IDX_W-1:0]   = pat_addr_q;
      A_PAT_DATA: readdata[DATA_W-1:0]  = pat_mem_q[pat_addr_q];
      default: ;
    endcase
  end

  assign out_port = out_q;
  assign irq      = done_q & irq_en_q;

endmodule
